instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
Fetch/execute sequencer for the 8-bit model CPU. It holds the instruction register, the fetch/execute phase bit (sm) and the carry/zero flag register, and decodes the IR into one-hot instruction strobes. It sits directly upstream of the control-signal generator, feeding it the IR, the strobes, sm, z and c. It takes back ir_ld, sm_en, cf_en and zf_en from the generator as registered feedback.

Parameters:
CNT_W, 8, width of the retired-instruction counter

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
ram_dout  in  8  instruction byte from RAM, sampled when ir_ld=1
ir_ld  in  1  load IR from ram_dout this edge
sm_en  in  1  toggle phase bit this edge
cf_en  in  1  capture alu_cf into c
zf_en  in  1  capture alu_zf into z
alu_cf  in  1  ALU carry-out
alu_zf  in  1  ALU zero result
ir  out  8  instruction register
sm  out  1  phase: 0 = fetch, 1 = execute
z, c  out  1 each  registered zero / carry flags
mova, movb, movc, add, sub, and1, not1, rsr, rsl, jmp, jz, jc, in1, out1, nop, halt  out  1 each  one-hot decoded strobes
halted  out  1  core stopped on HALT
instr_cnt  out  CNT_W  retired instructions, wraps

Behaviour:
- Reset (async, rst_n=0) forces: state=FETCH, ir=8'h00, sm=0, z=0, c=0, halted=0, instr_cnt=0, and all strobes=0. Reset mid-instruction abandons the instruction. There is no partial flag or IR update.
- FSM states: FETCH (sm=0), EXEC (sm=1), HALT (sm=1, halted=1).
  - FETCH -> EXEC when sm_en=1. Otherwise hold.
  - EXEC -> FETCH when sm_en=1.
  - EXEC -> HALT when sm_en=0 and the halt strobe is 1.
  - EXEC with sm_en=0 and no halt: hold.
  - HALT is left only by reset.
- IR: ir <= ram_dout on any edge with ir_ld=1, outside HALT. Otherwise hold. ir_ld is not gated by state; when driven correctly it is only asserted in FETCH.
- Flags: c <= alu_cf if cf_en; z <= alu_zf if zf_en. The two flags update independently. cf_en and zf_en may both be 1 in the same cycle. Flags are frozen in HALT.
- Decode: combinational from the ir register. All strobes are 0 in FETCH. Exactly one strobe is 1 in EXEC and HALT.
- Opcode ir[7:4]:
  - 0000 nop; 0001 halt; 0010 in1; 0011 out1
  - 0100 jmp; 0101 jz; 0110 jc
  - 0111 shift: ir[0]=0 gives rsr, ir[0]=1 gives rsl
  - 1000 add; 1001 sub; 1010 and1; 1011 not1
  - 1100 mova; 1101 movb; 1110 movc
  - 1111 decodes as nop
- ir[3:2] and ir[1:0] are passed through untouched inside ir. The downstream block uses them as register addresses.
- Latency: a byte on ram_dout at the FETCH edge (with ir_ld=1 and sm_en=1) appears on ir one cycle later, and its strobe is valid for the whole following EXEC cycle. Flags written in EXEC are visible from the next FETCH cycle, so a conditional jump sees flags from earlier instructions only.
- instr_cnt increments by 1 on every EXEC->FETCH transition and wraps from 2^CNT_W-1 to 0. The transition into HALT does not increment it.
- Every output is a flop except the strobes. The strobes are decoded purely from the ir and state flops, with no path from the feedback inputs, so there is no combinational loop through the downstream block.

Test Plan:
1. Reset then fetch: release rst_n, ram_dout=8'h84, ir_ld=1, sm_en=1 -> next cycle ir=8'h84, sm=1, add=1 and all other strobes 0. One more sm_en edge -> sm=0, strobes 0, instr_cnt=1.
2. Flag capture: in EXEC for SUB, alu_cf=1, alu_zf=1, cf_en=zf_en=1 -> c=1, z=1 next edge. Then cf_en=1, zf_en=0, alu_cf=0, alu_zf=0 -> c=0, z stays 1.
3. Full decode sweep: fetch each of the 16 opcodes plus 8'h70 and 8'h71 -> exactly the listed strobe is high in EXEC. 8'hF0 gives nop.
4. HALT: fetch 8'h10, then sm_en=0 in EXEC -> halted=1, sm=1, halt=1 and held. Toggling ir_ld, cf_en, sm_en for 10 cycles changes nothing, and instr_cnt is unchanged.
5. Counter wrap with CNT_W=8: run 256 NOP instructions -> instr_cnt returns to 0.
6. Async reset mid-EXEC: assert rst_n=0 between edges during a MOVC EXEC -> all outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/instr_sequencer.sv
// Fetch/execute sequencer for the 8-bit model CPU: instruction register, phase bit,
// carry/zero flags, retired-instruction counter and one-hot opcode decode.
module instr_sequencer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       ram_dout,
  input  logic             ir_ld,
  input  logic             sm_en,
  input  logic             cf_en,
  input  logic             zf_en,
  input  logic             alu_cf,
  input  logic             alu_zf,
  output logic [7:0]       ir,
  output logic             sm,
  output logic             z,
  output logic             c,
  output logic             mova,
  output logic             movb,
  output logic             movc,
  output logic             add,
  output logic             sub,
  output logic             and1,
  output logic             not1,
  output logic             rsr,
  output logic             rsl,
  output logic             jmp,
  output logic             jz,
  output logic             jc,
  output logic             in1,
  output logic             out1,
  output logic             nop,
  output logic             halt,
  output logic             halted,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Next-state logic; halt is decoded from flops only, so no loop via sm_en.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_FETCH: if (sm_en) state_nxt = ST_EXEC;
      ST_EXEC: begin
        if (sm_en)     state_nxt = ST_FETCH;
        else if (halt) state_nxt = ST_HALT;
      end
      ST_HALT:  state_nxt = ST_HALT;
      default:  state_nxt = ST_FETCH;
    endcase
  end

  // sm and halted are registered copies of the next state rather than decodes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_FETCH;
      sm        <= 1'b0;
      halted    <= 1'b0;
      instr_cnt <= '0;
    end else begin
      state  <= state_nxt;
      sm     <= (state_nxt != ST_FETCH);
      halted <= (state_nxt == ST_HALT);
      if (state == ST_EXEC && sm_en)
        instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

  // IR and flags freeze once the core has halted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir <= 8'h00;
      c  <= 1'b0;
      z  <= 1'b0;
    end else if (state != ST_HALT) begin
      if (ir_ld) ir <= ram_dout;
      if (cf_en) c  <= alu_cf;
      if (zf_en) z  <= alu_zf;
    end
  end

  always_comb begin
    mova = 1'b0;
    movb = 1'b0;
    movc = 1'b0;
    add  = 1'b0;
    sub  = 1'b0;
    and1 = 1'b0;
    not1 = 1'b0;
    rsr  = 1'b0;
    rsl  = 1'b0;
    jmp  = 1'b0;
    jz   = 1'b0;
    jc   = 1'b0;
    in1  = 1'b0;
    out1 = 1'b0;
    nop  = 1'b0;
    halt = 1'b0;
    if (state != ST_FETCH) begin
      case (ir[7:4])
        4'b0000: nop  = 1'b1;
        4'b0001: halt = 1'b1;
        4'b0010: in1  = 1'b1;
        4'b0011: out1 = 1'b1;
        4'b0100: jmp  = 1'b1;
        4'b0101: jz   = 1'b1;
        4'b0110: jc   = 1'b1;
        4'b0111: begin
          if (ir[0]) rsl = 1'b1;
          else       rsr = 1'b1;
        end
        4'b1000: add  = 1'b1;
        4'b1001: sub  = 1'b1;
        4'b1010: and1 = 1'b1;
        4'b1011: not1 = 1'b1;
        4'b1100: mova = 1'b1;
        4'b1101: movb = 1'b1;
        4'b1110: movc = 1'b1;
        default: nop  = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer with hand-computed expectations.
module tb_instr_sequencer;

  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] ram_dout = 8'h00;
  logic ir_ld = 1'b0, sm_en = 1'b0, cf_en = 1'b0, zf_en = 1'b0;
  logic alu_cf = 1'b0, alu_zf = 1'b0;
  logic [7:0] ir;
  logic sm, z, c, halted;
  logic mova, movb, movc, add, sub, and1, not1, rsr, rsl, jmp, jz, jc, in1, out1, nop, halt;
  logic [CNT_W-1:0] instr_cnt;
  logic [15:0] strb;

  int checks = 0;
  int errors = 0;

  instr_sequencer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .ram_dout(ram_dout), .ir_ld(ir_ld), .sm_en(sm_en),
    .cf_en(cf_en), .zf_en(zf_en), .alu_cf(alu_cf), .alu_zf(alu_zf),
    .ir(ir), .sm(sm), .z(z), .c(c),
    .mova(mova), .movb(movb), .movc(movc), .add(add), .sub(sub), .and1(and1),
    .not1(not1), .rsr(rsr), .rsl(rsl), .jmp(jmp), .jz(jz), .jc(jc),
    .in1(in1), .out1(out1), .nop(nop), .halt(halt),
    .halted(halted), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  assign strb = {mova, movb, movc, add, sub, and1, not1, rsr,
                 rsl, jmp, jz, jc, in1, out1, nop, halt};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle on the falling edge where outputs are sampled.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // FETCH edge loading b; leaves the DUT in EXEC with sm_en=1 queued to return to FETCH.
  task automatic fetch(input logic [7:0] b);
    ram_dout = b;
    ir_ld    = 1'b1;
    sm_en    = 1'b1;
    tick();
    ir_ld    = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [15:0] exp;
  } vec_t;

  vec_t sweep[19] = '{
    '{8'h00, 16'h0002}, '{8'h10, 16'h0001}, '{8'h20, 16'h0008}, '{8'h30, 16'h0004},
    '{8'h40, 16'h0040}, '{8'h50, 16'h0020}, '{8'h60, 16'h0010}, '{8'h70, 16'h0100},
    '{8'h71, 16'h0080}, '{8'h80, 16'h1000}, '{8'h90, 16'h0800}, '{8'hA0, 16'h0400},
    '{8'hB0, 16'h0200}, '{8'hC0, 16'h8000}, '{8'hD0, 16'h4000}, '{8'hE0, 16'h2000},
    '{8'hF0, 16'h0002}, '{8'h7E, 16'h0100}, '{8'h8F, 16'h1000}
  };

  initial begin
    // Reset state
    #2;
    check("rst_ir", ir, 8'h00);
    check("rst_sm", sm, 0);
    check("rst_flags", {z, c}, 0);
    check("rst_halted", halted, 0);
    check("rst_cnt", instr_cnt, 0);
    check("rst_strb", strb, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset then fetch of ADD
    fetch(8'h84);
    check("t1_ir", ir, 8'h84);
    check("t1_sm", sm, 1);
    check("t1_strb", strb, 16'h1000);
    check("t1_cnt_exec", instr_cnt, 0);
    tick();
    check("t1_sm_fetch", sm, 0);
    check("t1_strb_fetch", strb, 0);
    check("t1_cnt", instr_cnt, 1);

    // Flag capture during SUB
    fetch(8'h90);
    sm_en = 1'b0;
    alu_cf = 1'b1; alu_zf = 1'b1; cf_en = 1'b1; zf_en = 1'b1;
    tick();
    check("t2_sm_hold", sm, 1);
    check("t2_cz_both", {c, z}, 2'b11);
    alu_cf = 1'b0; alu_zf = 1'b0; cf_en = 1'b1; zf_en = 1'b0;
    tick();
    check("t2_c_only", {c, z}, 2'b01);
    cf_en = 1'b0;
    sm_en = 1'b1;
    tick();
    check("t2_sm_fetch", sm, 0);
    check("t2_cnt", instr_cnt, 2);

    // Decode sweep
    for (int i = 0; i < 19; i++) begin
      fetch(sweep[i].op);
      check($sformatf("t3_strb_%02h", sweep[i].op), strb, sweep[i].exp);
      check($sformatf("t3_ir_%02h", sweep[i].op), ir, sweep[i].op);
      tick();
      check($sformatf("t3_fetch_%02h", sweep[i].op), {sm, halted, strb}, 0);
    end
    check("t3_cnt", instr_cnt, 21);

    // Async reset mid-EXEC of MOVC, with c set first so the clear is visible
    fetch(8'hE0);
    sm_en = 1'b0;
    alu_cf = 1'b1; cf_en = 1'b1;
    tick();
    cf_en = 1'b0; alu_cf = 1'b0;
    check("t6_movc", strb, 16'h2000);
    check("t6_c_set", c, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_ir", ir, 8'h00);
    check("t6_sm", sm, 0);
    check("t6_flags", {z, c}, 0);
    check("t6_cnt", instr_cnt, 0);
    check("t6_strb", strb, 0);
    check("t6_halted", halted, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Counter wrap over 256 NOPs
    for (int i = 0; i < 256; i++) begin
      fetch(8'h00);
      tick();
      if (i == 254) check("t5_cnt_255", instr_cnt, 255);
    end
    check("t5_cnt_wrap", instr_cnt, 0);

    // HALT: entry does not count, then everything freezes
    fetch(8'h10);
    sm_en = 1'b0;
    check("t4_halt_strobe_exec", strb, 16'h0001);
    tick();
    check("t4_halted", halted, 1);
    check("t4_sm", sm, 1);
    check("t4_strb", strb, 16'h0001);
    check("t4_cnt", instr_cnt, 0);
    ram_dout = 8'hC3;
    alu_cf = 1'b1; alu_zf = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ir_ld = ~ir_ld;
      cf_en = ~cf_en;
      zf_en = ~zf_en;
      sm_en = ~sm_en;
      tick();
      check($sformatf("t4_hold_%0d", i),
            {ir, sm, halted, z, c, strb, instr_cnt},
            {8'h10, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0001, 8'h00});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
